array_extreme_scan: RTL and testbench
=====================================

# array_extreme_scan

Hardware scan engine that walks a contiguous window of word-addressed data memory and reports the maximum or minimum element and its index, replacing the software max-of-array loop run on the MIPS core. It sits beside the data cache as a second read master. It is started by a single-cycle pulse and reports through a done pulse plus held result registers. Width, address space and compare mode (max/min, signed/unsigned) are parametrised or selectable per run.

## Interface
- DATA_W, 32, element width in bits
- ADDR_W, 10, word-address width; LEN_W = ADDR_W+1 (derived, not overridable)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- base_addr  in  ADDR_W  word address of element 0
- length  in  LEN_W  element count (0..2^ADDR_W)
- find_min  in  1  0 = maximum, 1 = minimum
- signed_cmp  in  1  1 = two's-complement compare, 0 = unsigned
- mem_rd_en  out  1  one-cycle read request
- mem_addr  out  ADDR_W  read word address
- mem_rd_data  in  DATA_W  read data
- mem_rd_valid  in  1  read data valid (latency ≥1 cycle, one outstanding)
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  extreme value
- result_idx  out  LEN_W  index (0-based, relative to base_addr) of the extreme
- err  out  1  set with done when length==0

## Operation
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE: start=1 latches base_addr, length, find_min, signed_cmp; clears the index counter i. If length==0 → DONE with err=1, else → REQ.
- REQ: mem_rd_en=1, mem_addr=(base_addr+i) mod 2^ADDR_W (wraps silently) → WAIT.
- WAIT: hold until mem_rd_valid. Element i=0 loads best/best_idx unconditionally. For i>0, best is replaced only on strict improvement (data>best for max, data<best for min), so ties keep the lowest index. If i==length-1 → DONE, else i++ → REQ.
- DONE: result/result_idx/err update from internal registers, done=1 → IDLE.
- Compare: signed_cmp selects $signed vs unsigned on the full DATA_W.
- result, result_idx and err hold their value until the next DONE. err=1 forces result=0, result_idx=0.
- Inputs are ignored after acceptance. start while busy is ignored (no queueing).
- mem_rd_valid outside WAIT is ignored.
- mem_rd_en is never asserted outside REQ. At most one read is outstanding.

## Timing
- Reset (rst low, asynchronous): state=IDLE. busy, done, mem_rd_en, err = 0. result, result_idx, mem_addr, internal counters = 0.
- Reset mid-scan aborts with no done. A late mem_rd_valid after reset release is ignored.
- busy is 1 in REQ, WAIT and DONE, and 0 in IDLE.
- Memory latency L cycles (valid L cycles after the mem_rd_en cycle): start accepted at edge of cycle 0. Done is high in cycle N·(L+1)+1, where N is the element count.
- With L=1, N=10, done is high in cycle 21.
- length==0: done and err are high in cycle 1, with no memory access.
- Back-to-back runs: start may be asserted in the cycle after done; it is accepted that cycle.
- Index and address arithmetic is modulo 2^LEN_W and 2^ADDR_W respectively. No overflow flag.

## Test plan
- Memory [923,7,25,3,15,62,23,34,12,34] at base 0, length 10, max, unsigned, L=1 → result=923, result_idx=0, done in cycle 21, exactly 10 mem_rd_en pulses at addresses 0..9.
- Same memory, find_min=1 → result=3, result_idx=3. Then length=0 → done in cycle 1, err=1, result=0, zero reads.
- Memory [5, 0xFFFFFFFF, 5] → unsigned max gives 0xFFFFFFFF at idx 1. Signed max gives 5 at idx 0 (tie keeps first). Signed min gives 0xFFFFFFFF at idx 1.
- ADDR_W=4, base=14, length=4, memory[14,15,0,1]=[1,2,9,3] → reads at 14,15,0,1, result=9, result_idx=2. Repeat with L=3 → done in cycle 17.
- Reset asserted during WAIT of element 5 → all outputs 0 immediately, no done. A stray mem_rd_valid after release is ignored. A fresh run then gives the correct result.
- start pulsed while busy → ignored, result unchanged. start held high the cycle after done → second run accepted.

Source files
------------

// File: rtl/array_extreme_scan_if.sv
// Bus bundle for the extreme-scan engine: run control, memory read port and result.
// master = the scan engine, slave = the controller/memory side.
interface array_extreme_scan_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int LEN_W = ADDR_W + 1;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              find_min;
  logic              signed_cmp;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [LEN_W-1:0]  result_idx;
  logic              err;

  modport master (
    input  start, base_addr, length, find_min, signed_cmp, mem_rd_data, mem_rd_valid,
    output mem_rd_en, mem_addr, busy, done, result, result_idx, err
  );

  modport slave (
    output start, base_addr, length, find_min, signed_cmp, mem_rd_data, mem_rd_valid,
    input  mem_rd_en, mem_addr, busy, done, result, result_idx, err
  );
endinterface

// File: rtl/array_extreme_scan.sv
// Walks a window of word memory one read at a time and reports the max/min element
// and its index; ties keep the lowest index.
module array_extreme_scan #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input logic                  clk,
  input logic                  rst,
  array_extreme_scan_if.master bus
);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, idx;
  logic              min_q, sgn_q;
  logic [DATA_W-1:0] best, result_q;
  logic [LEN_W-1:0]  best_idx, result_idx_q;
  logic              err_q;
  logic              gt, lt, take, last;

  // Element 0 always seeds the running best; later ones need a strict improvement.
  always_comb begin
    gt   = sgn_q ? ($signed(bus.mem_rd_data) > $signed(best)) : (bus.mem_rd_data > best);
    lt   = sgn_q ? ($signed(bus.mem_rd_data) < $signed(best)) : (bus.mem_rd_data < best);
    take = (idx == '0) || (min_q ? lt : gt);
    last = (idx == len_q - LEN_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.length == '0) ? DONE : REQ;
      REQ:  state_nxt = WAIT;
      WAIT: if (bus.mem_rd_valid) state_nxt = last ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Result registers are loaded on the way into DONE so they are valid with the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q       <= '0;
      len_q        <= '0;
      idx          <= '0;
      min_q        <= 1'b0;
      sgn_q        <= 1'b0;
      best         <= '0;
      best_idx     <= '0;
      result_q     <= '0;
      result_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          base_q <= bus.base_addr;
          len_q  <= bus.length;
          min_q  <= bus.find_min;
          sgn_q  <= bus.signed_cmp;
          idx    <= '0;
          if (bus.length == '0) begin
            err_q        <= 1'b1;
            result_q     <= '0;
            result_idx_q <= '0;
          end
        end
        WAIT: if (bus.mem_rd_valid) begin
          if (take) begin
            best     <= bus.mem_rd_data;
            best_idx <= idx;
          end
          if (last) begin
            result_q     <= take ? bus.mem_rd_data : best;
            result_idx_q <= take ? idx : best_idx;
            err_q        <= 1'b0;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.mem_rd_en  = (state == REQ);
  assign bus.mem_addr   = base_q + idx[ADDR_W-1:0];
  assign bus.result     = result_q;
  assign bus.result_idx = result_idx_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_array_extreme_scan.sv
// Randomized and directed bench for array_extreme_scan against a behavioural memory/scan model.
module tb_array_extreme_scan;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  array_extreme_scan_if #(.DATA_W(32), .ADDR_W(10)) bus ();
  array_extreme_scan #(.DATA_W(32), .ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];
  int          lat = 1;
  int          cnt = 0;
  logic [9:0]  paddr = '0;
  bit          stray = 1'b0;

  // Memory: data returns lat cycles after the cycle mem_rd_en is seen high.
  always @(negedge clk) begin
    bus.mem_rd_valid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem[paddr];
      end
    end
    if (stray) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = 32'hDEAD_BEEF;
      stray = 1'b0;
    end
    if (bus.mem_rd_en) begin
      paddr = bus.mem_addr;
      cnt   = lat;
    end
  end

  // Reference: first element with the best key, key = value (signed or not), negated for min.
  function automatic void ref_scan(input int base, input int len, input bit fmin, input bit sgn,
                                   output logic [31:0] rv, output int ri);
    longint bk, key;
    logic [31:0] v;
    rv = '0; ri = 0; bk = 0;
    for (int k = 0; k < len; k++) begin
      v   = mem[(base + k) % 1024];
      key = sgn ? longint'($signed(v)) : longint'({32'd0, v});
      if (fmin) key = -key;
      if (k == 0 || key > bk) begin bk = key; rv = v; ri = k; end
    end
  endfunction

  task automatic run(input int base, input int len, input bit fmin, input bit sgn, input int l,
                     input int poke, output int cyc, output int nrd, output bit addr_ok,
                     output bit tmo);
    lat = l;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'(base); bus.length = 11'(len);
    bus.find_min = fmin; bus.signed_cmp = sgn;
    cyc = 0; nrd = 0; addr_ok = 1'b1; tmo = 1'b1;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (t == poke) begin
        bus.start = 1'b1; bus.length = '0; bus.find_min = ~fmin; bus.base_addr += 10'd5;
      end
      if (bus.mem_rd_en) begin
        if (bus.mem_addr !== 10'((base + nrd) % 1024)) addr_ok = 1'b0;
        nrd++;
      end
      if (bus.done) begin cyc = t; tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.mem_rd_en, bus.err} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.mem_rd_en, bus.err}); end
    n_cmp++; if ({bus.result, bus.result_idx, bus.mem_addr} !== 53'd0) begin n_err++;
      $display("FAIL reset_regs: got %h/%0d/%0d want 0", bus.result, bus.result_idx, bus.mem_addr); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_directed;
    int cyc, nrd; bit ok, tmo;
    logic [31:0] init [10] = '{923, 7, 25, 3, 15, 62, 23, 34, 12, 34};
    foreach (init[k]) mem[k] = init[k];
    run(0, 10, 1'b0, 1'b0, 1, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || cyc != 21) begin n_err++;
      $display("FAIL max_cycle: got %0d (timeout %0d) want 21", cyc, tmo); end
    n_cmp++; if (bus.result !== 32'd923 || bus.result_idx !== 11'd0 || bus.err !== 1'b0) begin n_err++;
      $display("FAIL max_val: got %0d@%0d err %b want 923@0 err 0", bus.result, bus.result_idx, bus.err); end
    n_cmp++; if (nrd != 10 || !ok) begin n_err++;
      $display("FAIL max_reads: got %0d reads addr_ok %0d want 10 reads addr_ok 1", nrd, ok); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.result !== 32'd923 || bus.done !== 1'b0) begin n_err++;
      $display("FAIL hold: got %0d done %b want 923 done 0", bus.result, bus.done); end
    run(0, 10, 1'b1, 1'b0, 1, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== 32'd3 || bus.result_idx !== 11'd3) begin n_err++;
      $display("FAIL min_val: got %0d@%0d want 3@3", bus.result, bus.result_idx); end
    run(0, 0, 1'b0, 1'b0, 1, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || cyc != 1 || nrd != 0) begin n_err++;
      $display("FAIL zero_len_timing: got cycle %0d reads %0d want cycle 1 reads 0", cyc, nrd); end
    n_cmp++; if (bus.err !== 1'b1 || bus.result !== 32'd0 || bus.result_idx !== 11'd0) begin n_err++;
      $display("FAIL zero_len_val: got err %b %0d@%0d want err 1 0@0", bus.err, bus.result, bus.result_idx); end
  endtask

  task automatic test_signed;
    int cyc, nrd; bit ok, tmo;
    mem[50] = 32'd5; mem[51] = 32'hFFFF_FFFF; mem[52] = 32'd5;
    run(50, 3, 1'b0, 1'b0, 2, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== 32'hFFFF_FFFF || bus.result_idx !== 11'd1) begin n_err++;
      $display("FAIL umax: got %h@%0d want ffffffff@1", bus.result, bus.result_idx); end
    run(50, 3, 1'b0, 1'b1, 2, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== 32'd5 || bus.result_idx !== 11'd0) begin n_err++;
      $display("FAIL smax_tie: got %h@%0d want 5@0", bus.result, bus.result_idx); end
    run(50, 3, 1'b1, 1'b1, 2, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== 32'hFFFF_FFFF || bus.result_idx !== 11'd1) begin n_err++;
      $display("FAIL smin: got %h@%0d want ffffffff@1", bus.result, bus.result_idx); end
  endtask

  task automatic test_wrap;
    int cyc, nrd; bit ok, tmo;
    mem[1022] = 32'd1; mem[1023] = 32'd2; mem[0] = 32'd9; mem[1] = 32'd3;
    for (int l = 1; l <= 3; l += 2) begin
      run(1022, 4, 1'b0, 1'b0, l, 0, cyc, nrd, ok, tmo);
      n_cmp++; if (tmo || bus.result !== 32'd9 || bus.result_idx !== 11'd2) begin n_err++;
        $display("FAIL wrap_val L=%0d: got %0d@%0d want 9@2", l, bus.result, bus.result_idx); end
      n_cmp++; if (cyc != 4 * (l + 1) + 1 || nrd != 4 || !ok) begin n_err++;
        $display("FAIL wrap_timing L=%0d: got cycle %0d reads %0d addr_ok %0d want cycle %0d reads 4 addr_ok 1",
                 l, cyc, nrd, ok, 4 * (l + 1) + 1); end
    end
  endtask

  task automatic test_random;
    int cyc, nrd, base, len, l, ri; bit ok, tmo, fmin, sgn;
    logic [31:0] rv, mask;
    for (int r = 0; r < 12; r++) begin
      base = $urandom_range(0, 1023); len = $urandom_range(1, 20); l = $urandom_range(1, 4);
      fmin = 1'($urandom); sgn = 1'($urandom);
      case ($urandom_range(0, 2)) 0: mask = 32'hF; 1: mask = 32'h8000_000F; default: mask = '1; endcase
      for (int k = 0; k < len; k++) mem[(base + k) % 1024] = $urandom & mask;
      ref_scan(base, len, fmin, sgn, rv, ri);
      run(base, len, fmin, sgn, l, 0, cyc, nrd, ok, tmo);
      n_cmp++; if (tmo || bus.result !== rv || bus.result_idx !== 11'(ri) || bus.err !== 1'b0) begin n_err++;
        $display("FAIL rand%0d_val: got %h@%0d err %b want %h@%0d err 0", r, bus.result, bus.result_idx,
                 bus.err, rv, ri); end
      n_cmp++; if (cyc != len * (l + 1) + 1 || nrd != len || !ok) begin n_err++;
        $display("FAIL rand%0d_timing: got cycle %0d reads %0d addr_ok %0d want cycle %0d reads %0d addr_ok 1",
                 r, cyc, nrd, ok, len * (l + 1) + 1, len); end
    end
  endtask

  task automatic test_reset_mid;
    int cyc, nrd, np, bad, ri; bit ok, tmo, hit;
    logic [31:0] rv;
    for (int k = 300; k < 310; k++) mem[k] = $urandom;
    lat = 2; np = 0; hit = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'd300; bus.length = 11'd10; bus.find_min = 1'b0; bus.signed_cmp = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_rd_en) np++;
      else if (np == 6) begin hit = 1'b1; break; end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL mid_reach: got %0d reads want element 5 wait", np); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.mem_rd_en, bus.err} !== 4'b0 ||
                 {bus.result, bus.result_idx, bus.mem_addr} !== 53'd0) begin n_err++;
      $display("FAIL mid_reset: got flags %b res %h@%0d addr %0d want all 0",
               {bus.busy, bus.done, bus.mem_rd_en, bus.err}, bus.result, bus.result_idx, bus.mem_addr); end
    @(negedge clk) rst = 1'b1;
    stray = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); if (bus.busy || bus.done || bus.mem_rd_en) bad++; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stray_valid: got %0d active cycles want 0", bad); end
    ref_scan(300, 10, 1'b0, 1'b0, rv, ri);
    run(300, 10, 1'b0, 1'b0, 2, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== rv || bus.result_idx !== 11'(ri) || cyc != 31) begin n_err++;
      $display("FAIL post_reset_run: got %h@%0d cycle %0d want %h@%0d cycle 31", bus.result, bus.result_idx,
               cyc, rv, ri); end
  endtask

  task automatic test_back_to_back;
    int cyc, nrd, ri; bit ok, tmo;
    logic [31:0] rv;
    for (int k = 100; k < 108; k++) mem[k] = $urandom;
    for (int k = 200; k < 205; k++) mem[k] = $urandom;
    ref_scan(100, 8, 1'b0, 1'b0, rv, ri);
    run(100, 8, 1'b0, 1'b0, 2, 5, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== rv || bus.result_idx !== 11'(ri) || cyc != 25 || nrd != 8 || !ok) begin
      n_err++; $display("FAIL busy_start: got %h@%0d cycle %0d reads %0d want %h@%0d cycle 25 reads 8",
                        bus.result, bus.result_idx, cyc, nrd, rv, ri); end
    bus.start = 1'b1;
    ref_scan(200, 5, 1'b1, 1'b1, rv, ri);
    run(200, 5, 1'b1, 1'b1, 1, 0, cyc, nrd, ok, tmo);
    n_cmp++; if (tmo || bus.result !== rv || bus.result_idx !== 11'(ri) || cyc != 11 || nrd != 5 || !ok) begin
      n_err++; $display("FAIL back_to_back: got %h@%0d cycle %0d reads %0d want %h@%0d cycle 11 reads 5",
                        bus.result, bus.result_idx, cyc, nrd, rv, ri); end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.find_min = 1'b0; bus.signed_cmp = 1'b0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    test_reset;
    test_directed;
    test_signed;
    test_wrap;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
